// File: rtl/bpg_clk_pkg.sv
// Shared constants and state encoding for the BPG clock divider sequencer.
package bpg_clk_pkg;

  localparam int DIV_W       = 16;
  localparam int DEFAULT_DIV = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

endpackage

// File: rtl/div_counter.sv
// Loadable down-counter holding the remaining cycles of the current half-period.
module div_counter #(
  parameter int           W         = 16,
  parameter logic [W-1:0] RESET_VAL = {{(W-2){1'b0}}, 2'b10}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] value,
  output logic         at_one
);

  logic [W-1:0] value_r;

  // Load has priority over decrement; the controller never decrements at one.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_r <= RESET_VAL;
    end else if (load) begin
      value_r <= load_val;
    end else if (en) begin
      value_r <= value_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      value_r <= value_r;
    end
  end

  assign value  = value_r;
  assign at_one = (value_r == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/clkdiv_sequencer.sv
// Run/stop and reconfiguration controller producing a glitch-free divided clock
// level and a tick enable; new ratios take effect only on half-period boundaries.
module clkdiv_sequencer #(
  parameter int WIDTH       = bpg_clk_pkg::DIV_W,
  parameter int DEFAULT_DIV = bpg_clk_pkg::DEFAULT_DIV
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             run,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_div,
  output logic             tick,
  output logic [WIDTH-1:0] div_active,
  output logic             pending,
  output logic             busy
);

  import bpg_clk_pkg::*;

  localparam logic [WIDTH-1:0] DEF_DIV_C = WIDTH'(DEFAULT_DIV);

  state_t           state_r, state_s;
  logic             clk_div_r, clk_div_s;
  logic             tick_r, tick_s;
  logic             cfg_err_r, cfg_err_s;
  logic             pending_r, pending_s;
  logic             cfg_ready_r;
  logic             busy_r;
  logic [WIDTH-1:0] div_active_r, div_active_s;
  logic [WIDTH-1:0] pend_div_r, pend_div_s;
  logic             cnt_load_s, cnt_en_s, at_one_s;
  logic [WIDTH-1:0] cnt_load_val_s, cnt_value_s;
  logic             xfer_s, cfg_zero_s;

  assign xfer_s     = cfg_valid & cfg_ready_r;
  assign cfg_zero_s = (cfg_div == {WIDTH{1'b0}});

  div_counter #(
    .W         (WIDTH),
    .RESET_VAL (DEF_DIV_C)
  ) u_counter (
    .clk      (clk_in),
    .reset    (reset),
    .load     (cnt_load_s),
    .load_val (cnt_load_val_s),
    .en       (cnt_en_s),
    .value    (cnt_value_s),
    .at_one   (at_one_s)
  );

  // Next-state, counter control and handshake decisions.
  always_comb begin
    state_s        = state_r;
    clk_div_s      = clk_div_r;
    tick_s         = 1'b0;
    cfg_err_s      = xfer_s & cfg_zero_s;
    pending_s      = pending_r;
    pend_div_s     = pend_div_r;
    div_active_s   = div_active_r;
    cnt_load_s     = 1'b0;
    cnt_load_val_s = div_active_r;
    cnt_en_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        clk_div_s = 1'b0;
        // A ratio parked on the stopping edge is drained here so it never sticks.
        if (pending_r) begin
          div_active_s = pend_div_r;
          pending_s    = 1'b0;
        end else if (xfer_s && !cfg_zero_s) begin
          div_active_s = cfg_div;
        end else begin
          div_active_s = div_active_r;
        end
        cnt_load_s     = 1'b1;
        cnt_load_val_s = div_active_s;
        if (run) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_RUN, ST_STOPPING: begin
        if (at_one_s) begin
          clk_div_s  = ~clk_div_r;
          tick_s     = 1'b1;
          cnt_load_s = 1'b1;
          if (pending_r) begin
            div_active_s   = pend_div_r;
            pending_s      = 1'b0;
            cnt_load_val_s = pend_div_r;
          end else begin
            cnt_load_val_s = div_active_r;
          end
        end else begin
          cnt_en_s = 1'b1;
        end
        // Applied after the boundary update so a same-edge transfer waits one more half-period.
        if (xfer_s && !cfg_zero_s) begin
          pend_div_s = cfg_div;
          pending_s  = 1'b1;
        end else begin
          pend_div_s = pend_div_r;
        end
        if (run) begin
          state_s = ST_RUN;
        end else if (state_r == ST_RUN) begin
          state_s = ST_STOPPING;
        end else if (at_one_s && clk_div_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_STOPPING;
        end
      end

      default: begin
        state_s   = ST_IDLE;
        clk_div_s = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      clk_div_r    <= 1'b0;
      tick_r       <= 1'b0;
      cfg_err_r    <= 1'b0;
      pending_r    <= 1'b0;
      cfg_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      div_active_r <= DEF_DIV_C;
      pend_div_r   <= DEF_DIV_C;
    end else begin
      state_r      <= state_s;
      clk_div_r    <= clk_div_s;
      tick_r       <= tick_s;
      cfg_err_r    <= cfg_err_s;
      pending_r    <= pending_s;
      cfg_ready_r  <= ~pending_s;
      busy_r       <= (state_s != ST_IDLE);
      div_active_r <= div_active_s;
      pend_div_r   <= pend_div_s;
    end
  end

  assign cfg_ready  = cfg_ready_r;
  assign cfg_err    = cfg_err_r;
  assign clk_div    = clk_div_r;
  assign tick       = tick_r;
  assign div_active = div_active_r;
  assign pending    = pending_r;
  assign busy       = busy_r;

endmodule
